// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller for the F/D/E pipeline registers: load-use detection,
// HI/LO (mult/div) busy tracking and a saturating stall-cycle counter.
module pipe_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_D,
  input  logic [4:0]       rt_D,
  input  logic             use_rs_D,
  input  logic             use_rt_D,
  input  logic             memread_E,
  input  logic [4:0]       rd_E,
  input  logic             md_start_E,
  input  logic             md_is_div_E,
  input  logic             md_use_D,
  output logic             en_F,
  output logic             en_D,
  output logic             en_E,
  output logic             clr_E,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_cnt,
  output logic [31:0]      stall_cnt
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             lu_haz, md_haz, stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // An issue while BUSY cannot happen in a legal program (the D-stage stall
  // holds the md instruction back), so BUSY ignores md_start_E entirely.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (md_start_E) begin
          state_d = BUSY;
          cnt_d   = md_is_div_E ? DIV_LD : MULT_LD;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign md_busy = (state_q == BUSY);

  // $0 is hardwired zero, so a load targeting it never creates a dependency.
  assign lu_haz = memread_E && (rd_E != 5'd0) &&
                  ((use_rs_D && (rs_D == rd_E)) || (use_rt_D && (rt_D == rd_E)));
  assign md_haz = md_use_D && (md_busy || md_start_E);
  assign stall  = lu_haz || md_haz;

  assign stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1
                                                                  : stall_cnt_q;

  // E never holds; a stall freezes F/D and turns the ID/EX slot into a bubble.
  assign en_F      = ~stall;
  assign en_D      = ~stall;
  assign en_E      = 1'b1;
  assign clr_E     = stall;
  assign md_cnt    = cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: table vectors, directed multi-cycle sequences and
// randomized traffic against a cycle-indexed reference model.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_D, rt_D, rd_E;
  logic        use_rs_D, use_rt_D, memread_E, md_start_E, md_is_div_E, md_use_D;
  logic        en_F, en_D, en_E, clr_E, md_busy;
  logic [3:0]  md_cnt;
  logic [31:0] stall_cnt;

  pipe_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D), .use_rs_D(use_rs_D),
    .use_rt_D(use_rt_D), .memread_E(memread_E), .rd_E(rd_E), .md_start_E(md_start_E),
    .md_is_div_E(md_is_div_E), .md_use_D(md_use_D), .en_F(en_F), .en_D(en_D),
    .en_E(en_E), .clr_E(clr_E), .md_busy(md_busy), .md_cnt(md_cnt), .stall_cnt(stall_cnt)
  );

  // clock block
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: cycle index, first cycle at which the HI/LO unit is free, stall count
  longint cyc_n   = 0;
  longint free_at = 0;
  longint sc      = 0;
  localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

  logic       obs_stall, obs_busy, obs_en_d;
  logic [3:0] obs_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // driver: apply one cycle of inputs, compare against the model mid-cycle, advance
  task automatic cyc(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                     input logic urt, input logic mr, input logic [4:0] rd,
                     input logic ms, input logic mdiv, input logic mu);
    logic   busy_m, lu_m, stall_m;
    longint cnt_m;
    rs_D = rs; rt_D = rt; use_rs_D = urs; use_rt_D = urt; memread_E = mr; rd_E = rd;
    md_start_E = ms; md_is_div_E = mdiv; md_use_D = mu;
    #4;
    busy_m  = (cyc_n < free_at);
    cnt_m   = busy_m ? (free_at - cyc_n) : 0;
    lu_m    = mr && (rd != 0) && ((urs && rs == rd) || (urt && rt == rd));
    stall_m = lu_m || (mu && (busy_m || ms));
    chk("en_F", {31'd0, en_F}, {31'd0, !stall_m});
    chk("en_D", {31'd0, en_D}, {31'd0, !stall_m});
    chk("en_E", {31'd0, en_E}, 32'd1);
    chk("clr_E", {31'd0, clr_E}, {31'd0, stall_m});
    chk("md_busy", {31'd0, md_busy}, {31'd0, busy_m});
    chk("md_cnt", {28'd0, md_cnt}, 32'(cnt_m));
    chk("stall_cnt", stall_cnt, 32'(sc));
    obs_stall = clr_E; obs_busy = md_busy; obs_cnt = md_cnt; obs_en_d = en_D;
    if (stall_m) sc = (sc + 1 > SAT) ? SAT : sc + 1;
    if (ms && !busy_m) free_at = cyc_n + 1 + (mdiv ? 10 : 5);
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic idle();
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [4:0] rs, rt, rd;
    logic       urs, urt, mr, mu;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // clock/reset block
    reset = 1'b1;
    rs_D = '0; rt_D = '0; rd_E = '0; use_rs_D = 0; use_rt_D = 0;
    memread_E = 0; md_start_E = 0; md_is_div_E = 0; md_use_D = 0;
    #3;
    chk("rst_md_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_md_cnt", {28'd0, md_cnt}, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_en_F", {31'd0, en_F}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // table vectors, no md activity
    vecs[0] = '{rs:8,  rt:0,  rd:8,  urs:1, urt:0, mr:1, mu:0, exp_stall:1};
    vecs[1] = '{rs:0,  rt:0,  rd:0,  urs:1, urt:0, mr:1, mu:0, exp_stall:0};
    vecs[2] = '{rs:3,  rt:9,  rd:9,  urs:1, urt:1, mr:1, mu:0, exp_stall:1};
    vecs[3] = '{rs:3,  rt:9,  rd:9,  urs:1, urt:0, mr:1, mu:0, exp_stall:0};
    vecs[4] = '{rs:12, rt:1,  rd:12, urs:1, urt:1, mr:0, mu:0, exp_stall:0};
    vecs[5] = '{rs:31, rt:31, rd:31, urs:0, urt:1, mr:1, mu:0, exp_stall:1};
    vecs[6] = '{rs:4,  rt:5,  rd:6,  urs:1, urt:1, mr:1, mu:0, exp_stall:0};
    vecs[7] = '{rs:0,  rt:0,  rd:0,  urs:1, urt:1, mr:1, mu:1, exp_stall:0};
    for (int i = 0; i < 8; i++) begin
      cyc(vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt, vecs[i].mr, vecs[i].rd,
          1'b0, 1'b0, vecs[i].mu);
      chk($sformatf("vec%0d_clr_E", i), {31'd0, obs_stall}, {31'd0, vecs[i].exp_stall});
      chk($sformatf("vec%0d_en_D", i), {31'd0, obs_en_d}, {31'd0, !vecs[i].exp_stall});
    end
    idle();
    chk("vec_stall_cnt", stall_cnt, 32'd3);

    // mult issue at t with mflo held in D: stall t..t+5, released at t+6
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    chk("mult_t_stall", {31'd0, obs_stall}, 32'd1);
    chk("mult_t_busy", {31'd0, obs_busy}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("mult_t%0d_busy", k), {31'd0, obs_busy}, 32'd1);
      chk($sformatf("mult_t%0d_cnt", k), {28'd0, obs_cnt}, 32'(6 - k));
      chk($sformatf("mult_t%0d_stall", k), {31'd0, obs_stall}, 32'd1);
    end
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("mult_t6_en_D", {31'd0, obs_en_d}, 32'd1);
    chk("mult_t6_busy", {31'd0, obs_busy}, 32'd0);

    // div issue: cnt 10..1 then 0; overlapping load-use in same cycle counts once
    cyc(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      idle();
      chk($sformatf("div_t%0d_cnt", k), {28'd0, obs_cnt}, 32'(11 - k));
    end
    idle();
    chk("div_t11_busy", {31'd0, obs_busy}, 32'd0);
    chk("div_t11_cnt", {28'd0, obs_cnt}, 32'd0);
    chk("div_stall_cnt", stall_cnt, 32'd10);

    // async reset while md_cnt == 3
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    chk("pre_rst_cnt", {28'd0, md_cnt}, 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_busy", {31'd0, md_busy}, 32'd0);
    chk("async_rst_cnt", {28'd0, md_cnt}, 32'd0);
    chk("async_rst_sc", stall_cnt, 32'd0);
    free_at = 0;
    sc = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc_n++;
    idle();
    chk("post_rst_clr_E", {31'd0, obs_stall}, 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
    end

    // saturation: preload near max, then stall continuously
    force dut.stall_cnt_q = 32'hFFFF_FFFC;
    #1;
    release dut.stall_cnt_q;
    sc = 64'h0000_0000_FFFF_FFFC;
    for (int i = 0; i < 8; i++) cyc(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    idle();
    chk("sat_stall_cnt", stall_cnt, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
